// File: rtl/instr_encoder_pkg.sv
// Shared opcode/funct constants, request op codes and loader FSM states.
// The opcodes must match the pipeline control decoder bit for bit.
package instr_encoder_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    localparam logic [2:0] IOP_LW   = 3'd0;
    localparam logic [2:0] IOP_ADDI = 3'd1;
    localparam logic [2:0] IOP_BEQ  = 3'd2;
    localparam logic [2:0] IOP_SW   = 3'd3;
    localparam logic [2:0] IOP_BNE  = 3'd4;
    localparam logic [2:0] IOP_ADD  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: request fields -> 32-bit instruction word.
// Codes with no encoding raise illegal and yield an all-zero word.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op)
            IOP_LW:   word = {OPC_LW,   rs, rt, imm};
            IOP_ADDI: word = {OPC_ADDI, rs, rt, imm};
            IOP_BEQ:  word = {OPC_BEQ,  rs, rt, imm};
            IOP_SW:   word = {OPC_SW,   rs, rt, imm};
            IOP_BNE:  word = {OPC_BNE,  rs, rt, imm};
            IOP_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FUNCT_ADD};
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-memory loader: encodes requests and writes them to consecutive
// word addresses through a single output register with a ready handshake.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [15:0]       count_q, count_d;
    logic              err_q, err_d;

    logic [31:0] pack_word;
    logic        pack_illegal;
    logic        drain;
    logic        accept;

    instr_pack u_pack (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        count_d  = count_q;
        err_d    = err_q;
        done     = 1'b0;
        drain    = we_q && imem_ready;
        // A word leaving this cycle frees the register for a new one.
        in_ready = (state_q == ST_LOAD) && (!we_q || imem_ready);
        accept   = in_valid && in_ready;

        if (drain) begin
            we_d   = 1'b0;
            addr_d = addr_q + ADDR_W'(4);
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    addr_d  = base_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (pack_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = pack_word;
                    end
                    if (in_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!we_q) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed + randomized bench for instr_encoder; a queue-based reference model
// predicts every memory write, final count and error flag.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last, imem_ready;
    logic [31:0] base_addr;
    logic [2:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic        in_ready, imem_we, busy, done, err;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] count;

    instr_encoder #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          ready_ctl = 0;   // 0: always ready, 1: never ready, 2: random
    wr_t         exp_q[$];
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    int          wr_c[$];
    logic [31:0] m_addr;
    int          m_count;
    logic        m_err;
    logic        acc, dn, obs_rdy;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_addr, hold_data;
    int          opc_tab[5] = '{35, 8, 4, 43, 5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                             input int rd, input int imm);
        if (op == 5) return 32'((rs << 21) + (rt << 16) + (rd << 11) + 32);
        return 32'((opc_tab[op] << 26) + (rs << 21) + (rt << 16) + imm);
    endfunction

    task automatic model_accept();
        wr_t e;
        if (in_op > 3'd5) begin
            m_err = 1'b1;
        end else begin
            e.a = m_addr;
            e.d = ref_word(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_imm));
            exp_q.push_back(e);
            m_addr = m_addr + 32'd4;
            m_count++;
        end
    endtask

    task automatic tick();
        wr_t e;
        case (ready_ctl)
            0:       imem_ready = 1'b1;
            1:       imem_ready = 1'b0;
            default: imem_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        acc = 1'b0; dn = 1'b0; obs_rdy = in_ready;
        if (!rst) begin
            if (hold_prev) begin
                chk("hold_we", 32'(imem_we), 32'd1);
                chk("hold_addr", imem_addr, hold_addr);
                chk("hold_data", imem_wdata, hold_data);
            end
            if (in_valid && in_ready) begin
                acc = 1'b1;
                model_accept();
            end
            if (imem_we && imem_ready) begin
                chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", imem_addr, e.a);
                    chk("wr_data", imem_wdata, e.d);
                end
                wr_a.push_back(imem_addr);
                wr_d.push_back(imem_wdata);
                wr_c.push_back(cyc);
            end
            dn = done;
            hold_prev = imem_we && !imem_ready;
            hold_addr = imem_addr;
            hold_data = imem_wdata;
        end else begin
            hold_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_session(input logic [31:0] base);
        m_addr = base; m_count = 0; m_err = 1'b0;
        exp_q.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete();
        start = 1'b1; base_addr = base;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic last);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (acc) break;
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic finish_session(input string tag);
        for (int i = 0; i < 64; i++) begin
            tick();
            if (dn) break;
        end
        chk({tag, "_done_seen"}, 32'(dn), 32'd1);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'(m_count));
        chk({tag, "_err"}, 32'(err), 32'(m_err));
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, 32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; imem_ready = 1'b1;
        base_addr = '0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
        m_addr = '0; m_count = 0; m_err = 1'b0;
        tick(); tick();
        check_reset_vals("reset");
        rst = 1'b0;

        // Single ADD
        ready_ctl = 0;
        begin_session(32'h100);
        chk("busy_load", 32'(busy), 32'd1);
        send(3'd5, 5'd1, 5'd2, 5'd3, 16'hBEEF, 1'b1);
        finish_session("add");
        chk("add_nwr", 32'(wr_a.size()), 32'd1);
        if (wr_a.size() >= 1) begin
            chk("add_addr", wr_a[0], 32'h100);
            chk("add_data", wr_d[0], 32'h00221820);
        end

        // LW then BNE back-to-back
        begin_session(32'h200);
        send(3'd0, 5'd0, 5'd8, 5'd31, 16'h0004, 1'b0);
        send(3'd4, 5'd8, 5'd0, 5'd0, 16'hFFFE, 1'b1);
        finish_session("lwbne");
        chk("lwbne_nwr", 32'(wr_a.size()), 32'd2);
        if (wr_a.size() >= 2) begin
            chk("lwbne_d0", wr_d[0], 32'h8C080004);
            chk("lwbne_d1", wr_d[1], 32'h1500FFFE);
            chk("lwbne_a1", wr_a[1], 32'h204);
            chk("lwbne_b2b", 32'(wr_c[1] - wr_c[0]), 32'd1);
        end

        // Three-cycle write stall
        begin_session(32'h300);
        ready_ctl = 1;
        send(3'd1, 5'd1, 5'd2, 5'd0, 16'h0005, 1'b0);
        in_op = 3'd1; in_rs = 5'd3; in_rt = 5'd4; in_rd = 5'd0; in_imm = 16'h8000;
        in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_in_ready", 32'(obs_rdy), 32'd0);
        end
        ready_ctl = 0;
        send(3'd1, 5'd3, 5'd4, 5'd0, 16'h8000, 1'b1);
        finish_session("stall");
        chk("stall_nwr", 32'(wr_a.size()), 32'd2);

        // Illegal op between two ADDIs
        begin_session(32'h400);
        send(3'd1, 5'd5, 5'd6, 5'd0, 16'h0011, 1'b0);
        send(3'd7, 5'd1, 5'd1, 5'd1, 16'h1234, 1'b0);
        chk("illegal_err", 32'(err), 32'd1);
        send(3'd1, 5'd7, 5'd8, 5'd0, 16'h0022, 1'b1);
        finish_session("illegal");
        chk("illegal_nwr", 32'(wr_a.size()), 32'd2);
        if (wr_a.size() >= 2) chk("illegal_a1", wr_a[1], 32'h404);

        // Address wrap
        begin_session(32'hFFFFFFFC);
        send(3'd3, 5'd2, 5'd9, 5'd0, 16'h0010, 1'b0);
        send(3'd3, 5'd2, 5'd10, 5'd0, 16'h0014, 1'b1);
        finish_session("wrap");
        if (wr_a.size() >= 2) begin
            chk("wrap_a0", wr_a[0], 32'hFFFFFFFC);
            chk("wrap_a1", wr_a[1], 32'h0);
        end

        // Reset mid-session with a held word
        begin_session(32'h500);
        ready_ctl = 1;
        send(3'd5, 5'd4, 5'd5, 5'd6, 16'h0, 1'b0);
        tick();
        chk("pre_rst_held", 32'(imem_we), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("midrst");
        exp_q.delete();
        ready_ctl = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_we", 32'(imem_we), 32'd0);
        end

        // Randomized sessions with random stalls and gaps
        ready_ctl = 2;
        for (int s = 0; s < 3; s++) begin
            begin_session({$urandom(), 2'b00} & 32'hFFFF_FFFC);
            for (int r = 0; r < 20; r++) begin
                logic [2:0] op;
                op = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1))
                                                 : 3'($urandom_range(0, 5));
                send(op, 5'($urandom()), 5'($urandom()), 5'($urandom()),
                     16'($urandom()), r == 19);
                if ($urandom_range(0, 3) == 0) tick();
            end
            finish_session("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, instruction-memory byte-address width.
REQ-002 SHALL have port: clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: start in 1 (begin load session); base_addr in ADDR_W (first word address, word-aligned).
REQ-005 SHALL have ports: in_valid in 1; in_ready out 1; in_last in 1 (final request of the session).
REQ-006 SHALL have ports: in_op in 3 (0=LW, 1=ADDI, 2=BEQ, 3=SW, 4=BNE, 5=ADD, 6-7 illegal); in_rs, in_rt, in_rd in 5 each; in_imm in 16.
REQ-007 SHALL have ports: imem_we out 1; imem_ready in 1; imem_addr out ADDR_W; imem_wdata out 32.
REQ-008 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); err out 1 (sticky illegal-op flag); count out 16 (words written this session).

Function
REQ-009 SHALL implement FSM IDLE -> LOAD -> DRAIN -> IDLE; start honoured only in IDLE; start outside IDLE is ignored.
REQ-010 On start in IDLE SHALL load the address register with base_addr, clear count and err, and enter LOAD the next cycle.
REQ-011 in_ready SHALL be 1 only in LOAD when the output register is empty or is being drained this cycle (imem_we && imem_ready).
REQ-012 A request SHALL be accepted on a cycle with in_valid && in_ready; the encoded word SHALL appear on imem_wdata with imem_we=1 on the next cycle (latency 1).
REQ-013 Encoding, fields [31:26|25:21|20:16|15:0]: LW 100011|rs|rt|imm; ADDI 001000|rs|rt|imm; BEQ 000100|rs|rt|imm; SW 101011|rs|rt|imm; BNE 000101|rs|rt|imm.
REQ-014 ADD SHALL encode 000000|rs|rt|rd|00000|100000; in_imm ignored for ADD, in_rd ignored for all others.
REQ-015 imem_we, imem_addr, imem_wdata SHALL hold stable while imem_we && !imem_ready.
REQ-016 On each write handshake (imem_we && imem_ready) the address SHALL advance by 4, wrapping modulo 2^ADDR_W, and count SHALL increment, saturating at 16'hFFFF.
REQ-017 An accepted illegal op SHALL set err, SHALL NOT produce a write, and SHALL NOT advance address or count.
REQ-018 Acceptance with in_last=1 SHALL move LOAD -> DRAIN; in DRAIN in_ready=0.
REQ-019 DRAIN -> IDLE SHALL occur once the output register is empty; done SHALL pulse for exactly that transition cycle.
REQ-020 Simultaneous drain of a held word and acceptance of a new request in the same cycle SHALL be supported without a bubble.
REQ-021 busy SHALL be 1 in LOAD and DRAIN, 0 in IDLE.

Reset
REQ-022 rst SHALL return FSM to IDLE from any state, discarding any pending word, mid-session included.
REQ-023 After reset: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, count=0.

Structure
REQ-024 Opcode constants (LW, ADDI, BEQ, SW, BNE, R-type), the ADD funct value, in_op codes and FSM state encodings SHALL live in a shared package, identical to the opcodes used by the pipeline control decoder.
REQ-025 The purely combinational field packer SHALL be a sub-module, instr_pack (op, rs, rt, rd, imm -> word, illegal flag); FSM, output register and counters stay in instr_encoder.

Verification
REQ-026 start, base_addr=0x100; ADD rs=1 rt=2 rd=3 with in_last; imem_ready=1 -> one write addr 0x100 data 0x00221820, done pulse, count=1.
REQ-027 LW rs=0 rt=8 imm=0x0004 then BNE rs=8 rt=0 imm=0xFFFE (last) -> writes 0x8C080004 @base, 0x1500FFFE @base+4, back-to-back.
REQ-028 imem_ready held 0 for 3 cycles during a write -> in_ready=0, addr/data stable, write completes when ready returns, no word lost or duplicated.
REQ-029 in_op=7 between two ADDIs -> err=1, exactly two writes at consecutive addresses, count=2.
REQ-030 base_addr=0xFFFFFFFC, two SW requests -> writes at 0xFFFFFFFC and 0x00000000.
REQ-031 rst asserted in LOAD with a held word -> no further imem_we, all outputs at reset values next cycle, new start works normally.
